// File: rtl/ahb2mem.sv
// AHB-Lite slave that turns each AHB transfer into a single request/response
// on a valid/ready memory port, with one transfer in flight at a time.
module ahb2mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsel,
  input  logic [1:0]          htrans,
  input  logic [2:0]          hburst,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic [2:0]          hsize,
  input  logic                hwrite,
  input  logic [DATA_W-1:0]   hwdata,
  input  logic [6:0]          hprot,
  input  logic                hmastlock,
  input  logic                hready,
  output logic                hreadyout,
  output logic                hresp,
  output logic [DATA_W-1:0]   hrdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_mask,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  input  logic                mem_resp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                accept;
  logic                unused;

  // Sizes above a word and sub-word transfers crossing their natural
  // alignment are rejected with an ERROR response.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      3'd0:    xfer_legal = 1'b1;
      3'd1:    xfer_legal = ~lsb[0];
      3'd2:    xfer_legal = (lsb == 2'b00);
      default: xfer_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    byte_mask = 4'b0001 << lsb;
      2'd1:    byte_mask = 4'b0011 << {lsb[1], 1'b0};
      default: byte_mask = 4'hF;
    endcase
  endfunction

  assign accept = hsel & htrans[1] & hready;
  assign unused = ^{htrans[0], hburst, hprot, hmastlock, size_q[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          addr_d  = haddr;
          write_d = hwrite;
          size_d  = hsize;
          state_d = xfer_legal(hsize, haddr[1:0]) ? S_REQ : S_ERR1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (mem_resp_valid) begin
          state_d = mem_resp_err ? S_ERR1 : S_DONE;
          // Only a successful read updates hrdata; errors and writes leave it.
          if (!mem_resp_err && !write_q) rdata_d = mem_resp_rdata;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  assign hreadyout      = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign hresp          = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign hrdata         = rdata_q;
  assign mem_req_valid  = (state_q == S_REQ);
  assign mem_req_addr   = addr_q;
  assign mem_req_wr     = write_q;
  assign mem_req_wdata  = hwdata;
  assign mem_req_mask   = byte_mask(size_q[1:0], addr_q[1:0]);
  assign mem_resp_ready = (state_q == S_RESP);

endmodule

// File: tb/tb_ahb2mem.sv
// Bench for ahb2mem: directed scenarios plus randomized transfers against a
// transaction-level model of the expected bus/memory behaviour.
module tb_ahb2mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [6:0]  hprot;
  logic        hmastlock;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        mem_resp_err;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rd = 32'h0;

  always #5 clk = ~clk;

  ahb2mem #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hburst(hburst),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hprot(hprot), .hmastlock(hmastlock), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
    .mem_req_wdata(mem_req_wdata), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  // One complete AHB transfer, starting #1 after an edge with the slave ready.
  // stall: cycles mem_req_ready stays low once a request is shown.
  // lat:   cycles spent in the response wait before mem_resp_valid rises.
  task automatic do_xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                         input logic [31:0] wd, input int stall, input int lat,
                         input logic err, input logic [31:0] rd, input string tag);
    logic       legal;
    logic [3:0] exp_mask;
    logic       seen_req;
    int         cycles, stall_cnt, lat_cnt, exp_cycles;
    legal = (sz == 3'd0) || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00);
    if (sz == 3'd0)      exp_mask = 4'(1 << a[1:0]);
    else if (sz == 3'd1) exp_mask = a[1] ? 4'b1100 : 4'b0011;
    else                 exp_mask = 4'b1111;

    total++;
    if (hreadyout !== 1'b1) begin
      bad++; $display("FAIL %s ready_at_start got=%b want=1", tag, hreadyout);
    end
    hsel = 1'b1; htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    hburst = 3'($urandom); haddr = a; hsize = sz; hwrite = wr; hready = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd; haddr = $urandom; hsize = 3'($urandom);
    hwrite = ~wr;

    total++;
    if (legal && mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL %s req_next_cycle got=%b want=1", tag, mem_req_valid);
    end else if (!legal && (hresp !== 1'b1 || hreadyout !== 1'b0)) begin
      bad++; $display("FAIL %s err1 got hresp=%b hreadyout=%b want 1/0", tag, hresp, hreadyout);
    end

    seen_req = 1'b0; cycles = 0; stall_cnt = 0; lat_cnt = 0;
    while (hreadyout !== 1'b1 && cycles < 60) begin
      if (mem_req_valid === 1'b1) begin
        seen_req = 1'b1;
        total++;
        if (mem_req_addr !== a || mem_req_wr !== wr || mem_req_mask !== exp_mask ||
            (wr && mem_req_wdata !== wd)) begin
          bad++;
          $display("FAIL %s req_fields got a=%h wr=%b m=%b wd=%h want a=%h wr=%b m=%b wd=%h",
                   tag, mem_req_addr, mem_req_wr, mem_req_mask, mem_req_wdata, a, wr, exp_mask, wd);
        end
        mem_req_ready = (stall_cnt >= stall);
        stall_cnt++;
      end else begin
        mem_req_ready = 1'b0;
      end
      if (mem_resp_ready === 1'b1) begin
        mem_resp_valid = (lat_cnt >= lat);
        mem_resp_err   = err;
        mem_resp_rdata = rd;
        lat_cnt++;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = $urandom;
      end
      @(posedge clk); #1;
      cycles++;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;

    if (legal) exp_cycles = stall + 1 + lat + 1 + (err ? 1 : 0);
    else       exp_cycles = 1;
    total++;
    if (cycles !== exp_cycles) begin
      bad++; $display("FAIL %s wait_states got=%0d want=%0d", tag, cycles, exp_cycles);
    end
    total++;
    if (seen_req !== legal) begin
      bad++; $display("FAIL %s mem_req_issued got=%b want=%b", tag, seen_req, legal);
    end
    total++;
    if (hresp !== (!legal || err) || hreadyout !== 1'b1) begin
      bad++; $display("FAIL %s completion got hresp=%b hreadyout=%b want %b/1",
                      tag, hresp, hreadyout, (!legal || err));
    end
    if (legal && !wr && !err) model_rd = rd;
    total++;
    if (hrdata !== model_rd) begin
      bad++; $display("FAIL %s hrdata got=%h want=%h", tag, hrdata, model_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hburst = 3'd0; haddr = 32'h0; hsize = 3'd0;
    hwrite = 1'b0; hwdata = 32'h0; hprot = 7'h0; hmastlock = 1'b0; hready = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0; mem_resp_err = 1'b0;
    #12;
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 ||
        mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_values got rdy=%b resp=%b rd=%h rv=%b rr=%b want 1/0/0/0/0",
               hreadyout, hresp, hrdata, mem_req_valid, mem_resp_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_read();
    do_xfer(32'h100, 3'd2, 1'b0, 32'h0, 0, 1, 1'b0, 32'hDEADBEEF, "word_read");
  endtask

  task automatic test_byte_write();
    do_xfer(32'h203, 3'd0, 1'b1, 32'hAB000000, 0, 0, 1'b0, 32'h0, "byte_write");
  endtask

  task automatic test_misaligned();
    do_xfer(32'h102, 3'd2, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0, "misaligned_word");
    do_xfer(32'h201, 3'd1, 1'b1, 32'h1234, 0, 0, 1'b0, 32'h0, "misaligned_half");
    do_xfer(32'h200, 3'd3, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0, "oversize");
  endtask

  task automatic test_mem_error();
    do_xfer(32'h40, 3'd2, 1'b0, 32'h0, 0, 0, 1'b1, 32'h55AA55AA, "mem_error");
  endtask

  task automatic test_idle();
    logic [1:0] tr [4] = '{2'b10, 2'b00, 2'b01, 2'b10};
    logic       sl [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      hsel = sl[i]; htrans = tr[i]; hready = rdy[i]; haddr = 32'h80; hsize = 3'd2;
      @(posedge clk); #1;
      total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || mem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_%0d got rdy=%b resp=%b rv=%b want 1/0/0", i, hreadyout, hresp, mem_req_valid);
      end
    end
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_xfer(32'h10, 3'd2, 1'b1, 32'hCAFEF00D, 5, 0, 1'b0, 32'h0, "b2b_write");
    do_xfer(32'h14, 3'd2, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0BADF00D, "b2b_read");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < 60; i++) begin
      a  = $urandom & 32'h0000_0FFF;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_xfer(a, sz, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom, "random");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h300; hsize = 3'd2; hwrite = 1'b0; hready = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    n = 0;
    while (mem_resp_ready !== 1'b1 && n < 20) begin
      mem_req_ready = mem_req_valid;
      @(posedge clk); #1;
      n++;
    end
    mem_req_ready = 1'b0;
    total++;
    if (mem_resp_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_reach_resp got=%b want=1", mem_resp_ready);
    end
    rst = 1'b1;
    #1;
    total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 ||
        mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_values got rdy=%b resp=%b rd=%h rv=%b rr=%b want 1/0/0/0/0",
               hreadyout, hresp, hrdata, mem_req_valid, mem_resp_ready);
    end
    model_rd = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_xfer(32'h304, 3'd2, 1'b0, 32'h0, 0, 1, 1'b0, 32'h600DCAFE, "after_reset_read");
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_misaligned();
    test_mem_error();
    test_idle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
